// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, instruction-format helpers and
// default geometry for the fetch stage.
package cpu_pkg;

    localparam int DEF_ADDR_W    = 20;
    localparam int DEF_INSTR_W   = 16;
    localparam int DEF_RESET_VEC = 0;
    localparam int IMM_FLAG_BIT  = 15;

    typedef enum logic [1:0] {
        BOOT_HI   = 2'd0,
        BOOT_LO   = 2'd1,
        FETCH     = 2'd2,
        FETCH_IMM = 2'd3
    } fetch_state_t;

    // A set flag bit marks the first word of a two-word (immediate) instruction.
    function automatic logic is_two_word(input logic [DEF_INSTR_W-1:0] word);
        return word[IMM_FLAG_BIT];
    endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter: load beats increment beats hold; arithmetic wraps at 2^ADDR_W.
module pc_reg #(
    parameter int ADDR_W = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_next
);

    assign pc_next = pc + ADDR_W'(1);

    // PC update: load target, step by one word, or hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            pc <= '0;
        else if (load)
            pc <= load_val;
        else if (inc)
            pc <= pc_next;
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: boots the PC from a two-word vector, fetches 16-bit words
// and packs two-word instructions into one 32-bit packet for IF/ID.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int                ADDR_W    = DEF_ADDR_W,
    parameter int                INSTR_W   = DEF_INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(DEF_RESET_VEC)
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic [ADDR_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0]   imem_data,
    input  logic                 stall,
    input  logic                 redirect_en,
    input  logic [ADDR_W-1:0]    redirect_pc,
    output logic [2*INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]    if_pc,
    output logic [ADDR_W-1:0]    if_pc_next,
    output logic                 if_valid
);

    fetch_state_t         state;
    logic [INSTR_W-1:0]   hi_q;
    logic [INSTR_W-1:0]   word0_q;
    logic [ADDR_W-1:0]    pc;
    logic [ADDR_W-1:0]    pc_next;
    logic [ADDR_W-1:0]    pc_load_val;
    logic                 pc_load;
    logic                 pc_inc;
    logic [2*INSTR_W-1:0] boot_word;

    assign boot_word = {hi_q, imem_data};

    pc_reg #(.ADDR_W(ADDR_W)) u_pc (
        .clk      (clk),
        .reset    (reset),
        .load     (pc_load),
        .load_val (pc_load_val),
        .inc      (pc_inc),
        .pc       (pc),
        .pc_next  (pc_next)
    );

    // Memory address and PC control; boot states ignore stall and redirect.
    always_comb begin
        imem_addr   = pc;
        pc_load     = 1'b0;
        pc_load_val = redirect_pc;
        pc_inc      = 1'b0;
        case (state)
            BOOT_HI: imem_addr = RESET_VEC;
            BOOT_LO: begin
                imem_addr   = RESET_VEC + ADDR_W'(1);
                pc_load     = 1'b1;
                pc_load_val = boot_word[ADDR_W-1:0];
            end
            default: begin
                if (redirect_en)
                    pc_load = 1'b1;
                else if (!stall)
                    pc_inc = 1'b1;
            end
        endcase
    end

    // Fetch FSM and IF/ID output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= BOOT_HI;
            hi_q       <= '0;
            word0_q    <= '0;
            if_instr   <= '0;
            if_pc      <= '0;
            if_pc_next <= '0;
            if_valid   <= 1'b0;
        end else begin
            case (state)
                BOOT_HI: begin
                    hi_q  <= imem_data;
                    state <= BOOT_LO;
                end
                BOOT_LO: state <= FETCH;
                FETCH: begin
                    if (redirect_en) begin
                        if_valid <= 1'b0;
                    end else if (!stall) begin
                        if (is_two_word(imem_data)) begin
                            word0_q  <= imem_data;
                            if_valid <= 1'b0;
                            state    <= FETCH_IMM;
                        end else begin
                            if_instr   <= {imem_data, INSTR_W'(0)};
                            if_pc      <= pc;
                            if_pc_next <= pc_next;
                            if_valid   <= 1'b1;
                        end
                    end
                end
                FETCH_IMM: begin
                    // A redirect drops the half-fetched instruction in word0_q.
                    if (redirect_en) begin
                        if_valid <= 1'b0;
                        state    <= FETCH;
                    end else if (!stall) begin
                        if_instr   <= {word0_q, imem_data};
                        if_pc      <= pc - ADDR_W'(1);
                        if_pc_next <= pc_next;
                        if_valid   <= 1'b1;
                        state      <= FETCH;
                    end
                end
                default: state <= BOOT_HI;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: expected packets go into a scoreboard queue
// and a negedge monitor compares each newly presented instruction.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic [19:0] imem_addr;
    logic [15:0] imem_data;
    logic        stall;
    logic        redirect_en;
    logic [19:0] redirect_pc;
    logic [31:0] if_instr;
    logic [19:0] if_pc;
    logic [19:0] if_pc_next;
    logic        if_valid;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] instr;
        logic [19:0] pc;
        logic [19:0] pc_next;
    } exp_t;
    exp_t sb_q[$];

    logic [15:0] mem [0:255];
    logic [15:0] top_word;
    logic        stall_at_edge;

    assign imem_data = (imem_addr == 20'hFFFFF) ? top_word :
                       (imem_addr < 20'd256)    ? mem[imem_addr[7:0]] : 16'h0000;

    fetch_stage dut (
        .clk         (clk),
        .reset       (reset),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .stall       (stall),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_pc_next  (if_pc_next),
        .if_valid    (if_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] i, input logic [19:0] p, input logic [19:0] n);
        exp_t e;
        e.instr = i; e.pc = p; e.pc_next = n;
        sb_q.push_back(e);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Remember whether the last edge was stalled: a held output is not a new instruction.
    initial stall_at_edge = 1'b1;
    always @(posedge clk) stall_at_edge <= stall;

    // Monitor: every freshly registered valid packet must match the queue head.
    always @(negedge clk) begin
        if (reset && if_valid && !stall_at_edge) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected actual=%h@%h required=none", if_instr, if_pc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_instr",   if_instr,   e.instr);
                chk("sb_pc",      if_pc,      e.pc);
                chk("sb_pc_next", if_pc_next, e.pc_next);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; stall = 1'b0; redirect_en = 1'b0; redirect_pc = '0;
        top_word = 16'h0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0;
        mem[8'h00] = 16'h0000; mem[8'h01] = 16'h0010;
        mem[8'h10] = 16'h1234; mem[8'h11] = 16'h0005;
        mem[8'h12] = 16'h8123; mem[8'h13] = 16'hBEEF;
        mem[8'h14] = 16'h0001; mem[8'h15] = 16'h8AAA;
        mem[8'h16] = 16'h5555; mem[8'h40] = 16'h0042;
        mem[8'h41] = 16'h0000; mem[8'h42] = 16'h8001;
        #12;
        chk("rst_instr", if_instr, 32'h0);
        chk("rst_pc", {12'h0, if_pc}, 32'h0);
        chk("rst_pc_next", {12'h0, if_pc_next}, 32'h0);
        chk("rst_valid", {31'h0, if_valid}, 32'h0);
        chk("rst_addr", {12'h0, imem_addr}, 32'h0);

        // Boot: vector 0x00000010
        @(posedge clk); #1; reset = 1'b1;
        chk("boot_addr_c1", {12'h0, imem_addr}, 32'h0);
        tick;
        chk("boot_addr_c2", {12'h0, imem_addr}, 32'h1);
        chk("boot_valid_c2", {31'h0, if_valid}, 32'h0);
        tick;
        chk("boot_addr_c3", {12'h0, imem_addr}, 32'h10);
        chk("boot_valid_c3", {31'h0, if_valid}, 32'h0);
        push(32'h12340000, 20'h10, 20'h11);
        push(32'h00050000, 20'h11, 20'h12);
        tick;
        chk("boot_first_valid", {31'h0, if_valid}, 32'h1);
        chk("boot_first_pc", {12'h0, if_pc}, 32'h10);
        tick;
        chk("pre_stall_pc", {12'h0, if_pc}, 32'h11);

        // Stall three cycles with if_pc=0x11
        stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick;
            chk("stall_pc", {12'h0, if_pc}, 32'h11);
            chk("stall_instr", if_instr, 32'h00050000);
            chk("stall_addr", {12'h0, imem_addr}, 32'h12);
        end
        stall = 1'b0;

        // Two-word at 0x12, then one-word at 0x14
        push(32'h8123BEEF, 20'h12, 20'h14);
        push(32'h00010000, 20'h14, 20'h15);
        tick;
        chk("imm_bubble", {31'h0, if_valid}, 32'h0);
        chk("imm_addr", {12'h0, imem_addr}, 32'h13);
        tick;
        tick;
        chk("after_imm_addr", {12'h0, imem_addr}, 32'h15);

        // Two-word at 0x15 interrupted by redirect (with stall) in FETCH_IMM
        tick;
        chk("pre_redir_bubble", {31'h0, if_valid}, 32'h0);
        chk("pre_redir_addr", {12'h0, imem_addr}, 32'h16);
        redirect_en = 1'b1; redirect_pc = 20'h40; stall = 1'b1;
        tick;
        redirect_en = 1'b0; stall = 1'b0;
        chk("redir_valid", {31'h0, if_valid}, 32'h0);
        chk("redir_addr", {12'h0, imem_addr}, 32'h40);
        chk("redir_keep_pc", {12'h0, if_pc}, 32'h14);
        chk("redir_keep_instr", if_instr, 32'h00010000);
        push(32'h00420000, 20'h40, 20'h41);
        push(32'h00000000, 20'h41, 20'h42);
        tick;
        tick;
        chk("post_redir_addr", {12'h0, imem_addr}, 32'h42);
        tick;
        chk("midrst_bubble", {31'h0, if_valid}, 32'h0);

        // Reset during FETCH_IMM
        #2; reset = 1'b0; #1;
        chk("midrst_instr", if_instr, 32'h0);
        chk("midrst_pc", {12'h0, if_pc}, 32'h0);
        chk("midrst_pc_next", {12'h0, if_pc_next}, 32'h0);
        chk("midrst_valid", {31'h0, if_valid}, 32'h0);
        chk("midrst_addr", {12'h0, imem_addr}, 32'h0);
        @(posedge clk); #1; reset = 1'b1;
        push(32'h12340000, 20'h10, 20'h11);
        tick; tick; tick;
        chk("reboot_pc", {12'h0, if_pc}, 32'h10);
        @(negedge clk); #1; reset = 1'b0;

        // Wrap: one-word at 0xFFFFF
        mem[8'h00] = 16'h000F; mem[8'h01] = 16'hFFFF; top_word = 16'h0007;
        @(posedge clk); #1; reset = 1'b1;
        push(32'h00070000, 20'hFFFFF, 20'h00000);
        push(32'h000F0000, 20'h00000, 20'h00001);
        tick; tick; tick;
        chk("wrap_pc_next", {12'h0, if_pc_next}, 32'h0);
        chk("wrap_addr", {12'h0, imem_addr}, 32'h0);
        tick;
        chk("wrap_next_addr", {12'h0, imem_addr}, 32'h1);
        @(negedge clk); #1; reset = 1'b0;

        // Wrap: two-word at 0xFFFFF takes its immediate from address 0
        top_word = 16'h8007;
        @(posedge clk); #1; reset = 1'b1;
        push(32'h8007000F, 20'hFFFFF, 20'h00001);
        tick; tick; tick;
        chk("wrap2_bubble", {31'h0, if_valid}, 32'h0);
        chk("wrap2_addr", {12'h0, imem_addr}, 32'h0);
        tick;
        chk("wrap2_addr_after", {12'h0, imem_addr}, 32'h1);
        @(negedge clk); #1; reset = 1'b0;
        tick; tick;

        chk("sb_drained", sb_q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage at the head of the five-stage pipeline. It feeds the IF/ID register inside Processor.
- After reset it boots the PC from a reset vector held in instruction memory.
- It fetches 16-bit instruction words and assembles two-word (immediate) instructions into a single 32-bit packet.
- It honours stall from the hazard unit and redirect (branch/jump/return) from later stages.

Parameters:
ADDR_W, 20, PC and instruction-memory address width; PC arithmetic is modulo 2^ADDR_W.
INSTR_W, 16, instruction-memory word width.
RESET_VEC, 0, address of the boot vector: high word at RESET_VEC, low word at RESET_VEC+1.

Ports:
clk  in  1  clock; all state changes on rising edge.
reset  in  1  asynchronous, active-low reset.
imem_addr  out  ADDR_W  instruction-memory read address; combinational from state/PC.
imem_data  in  INSTR_W  instruction-memory read data; asynchronous read, valid in the same cycle.
stall  in  1  hold the fetch stage (load-use or structural hazard).
redirect_en  in  1  take redirect_pc as the next PC.
redirect_pc  in  ADDR_W  redirect target.
if_instr  out  2*INSTR_W  registered packet {word0, word1}; word1 = 0 for one-word instructions.
if_pc  out  ADDR_W  registered address of word0.
if_pc_next  out  ADDR_W  registered address following the whole instruction (used for CALL).
if_valid  out  1  registered; 1 = if_instr holds a real instruction, 0 = bubble.

Behaviour:
- Reset (reset==0, asynchronous):
  - state=BOOT_HI, pc=0, hi_q=0, word0_q=0.
  - if_instr=0, if_pc=0, if_pc_next=0, if_valid=0.
- States: BOOT_HI, BOOT_LO, FETCH, FETCH_IMM.
- BOOT_HI:
  - imem_addr=RESET_VEC; hi_q<=imem_data; go to BOOT_LO.
  - stall and redirect are ignored; if_valid stays 0.
- BOOT_LO:
  - imem_addr=RESET_VEC+1; pc<={hi_q,imem_data}[ADDR_W-1:0]; go to FETCH.
  - stall and redirect are ignored; if_valid stays 0.
- Boot latency: the first real instruction appears at if_* on the 3rd rising edge after reset deasserts.
- FETCH: imem_addr=pc.
  - Two-word test: word is two-word iff imem_data[15]==1.
  - One-word: if_instr<={imem_data,16'h0}, if_pc<=pc, if_pc_next<=pc+1, if_valid<=1, pc<=pc+1.
  - Two-word: word0_q<=imem_data, pc<=pc+1, if_valid<=0 (bubble), go to FETCH_IMM.
- FETCH_IMM: imem_addr=pc.
  - if_instr<={word0_q,imem_data}, if_pc<=pc-1, if_pc_next<=pc+1, if_valid<=1, pc<=pc+1, go to FETCH.
- Priority in FETCH/FETCH_IMM: redirect_en > stall > normal.
- Redirect:
  - pc<=redirect_pc, if_valid<=0, go to FETCH.
  - A partially fetched two-word instruction is discarded.
  - if_instr, if_pc and if_pc_next keep their old values.
- Stall (no redirect): pc, state, word0_q and all if_* outputs hold; imem_addr is unchanged.
- Wrap-around: pc+1 and pc-1 wrap modulo 2^ADDR_W. A two-word instruction at 2^ADDR_W-1 takes its immediate from address 0.
- Reset asserted mid-operation: immediate return to reset values and a full re-boot; in-flight fetch is lost.
- Throughput: one one-word instruction per cycle; a two-word instruction costs 2 cycles (one bubble).

Decomposition:
- Shared package cpu_pkg:
  - fetch state enum;
  - IMM_FLAG_BIT=15;
  - INSTR_W, ADDR_W and RESET_VEC defaults;
  - is_two_word(word) function, also used by the decode stage.
- One natural sub-module: pc_reg (PC register with load/increment/hold and wrap).
- FSM and output registers live in fetch_stage.

Test Plan:
- Boot: M[0]=0x0000, M[1]=0x0010, M[0x10]=0x1234 (one-word), release reset → cycle 1 imem_addr=0, cycle 2 imem_addr=1, cycle 3 imem_addr=0x10. After the 3rd edge: if_valid=1, if_instr=0x12340000, if_pc=0x10, if_pc_next=0x11.
- Two-word: M[0x10]=0x8123, M[0x11]=0xBEEF, M[0x12]=0x0001 → bubble (if_valid=0), then if_instr=0x8123BEEF, if_pc=0x10, if_pc_next=0x12, then 0x00010000 at 0x12.
- Stall: assert stall 3 cycles while if_pc=0x11 → if_* and imem_addr constant for 3 cycles; fetch resumes at 0x12 without loss or duplication.
- Redirect: redirect_en=1, redirect_pc=0x40 during FETCH_IMM (stall=1 simultaneously) → if_valid=0 next cycle, word0 discarded, imem_addr=0x40; M[0x40] delivered next.
- Wrap: PC boots to 0xFFFFF, M[0xFFFFF]=0x0007 → if_pc=0xFFFFF, if_pc_next=0x00000, next imem_addr=0.
- Reset mid-run: assert reset during FETCH_IMM → all outputs 0 immediately; after release, boot repeats from RESET_VEC.
